// File: rtl/uart_cmd_parser_if.sv
// Byte stream in, held command out, payload read port and error counters between the parser and the GPU core.
// master = parser side, slave = UART/core side.
interface uart_cmd_parser_if #(
  parameter int MAX_PAYLOAD = 16
);
  localparam int LW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = $clog2(MAX_PAYLOAD);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_op;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;
  logic [7:0]    err_chk;
  logic [7:0]    err_len;
  logic [7:0]    err_drop;
  logic [7:0]    err_tmo;

  modport master (
    input  rx_data, rx_valid, cmd_ready, pl_addr,
    output cmd_valid, cmd_op, cmd_len, pl_data, err_chk, err_len, err_drop, err_tmo
  );

  modport slave (
    output rx_data, rx_valid, cmd_ready, pl_addr,
    input  cmd_valid, cmd_op, cmd_len, pl_data, err_chk, err_len, err_drop, err_tmo
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Frames SYNC/OP/LEN/payload/CHK bytes into one held command; cmd_valid rises the edge after a good CHK byte.
// Never stalls the UART: bytes arriving while a command is held are dropped and counted.
module uart_cmd_parser #(
  parameter int         MAX_PAYLOAD    = 16,
  parameter int         TIMEOUT_CYCLES = 2_000_000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  uart_cmd_parser_if.master  bus
);
  localparam int LW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = $clog2(MAX_PAYLOAD);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OP,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    cmd_op_q, cmd_op_d;
  logic [LW-1:0] cmd_len_q, cmd_len_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    err_chk_q, err_chk_d;
  logic [7:0]    err_len_q, err_len_d;
  logic [7:0]    err_drop_q, err_drop_d;
  logic [7:0]    err_tmo_q, err_tmo_d;
  logic [7:0]    pl_data_q, pl_data_d;

  logic [7:0]    pl_mem [MAX_PAYLOAD];
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    cmd_op_d   = cmd_op_q;
    cmd_len_d  = cmd_len_q;
    tmo_d      = '0;
    err_chk_d  = err_chk_q;
    err_len_d  = err_len_q;
    err_drop_d = err_drop_q;
    err_tmo_d  = err_tmo_q;
    wr_en      = 1'b0;
    wr_addr    = idx_q[AW-1:0];
    pl_data_d  = pl_mem[bus.pl_addr];

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) state_d = ST_OP;
      end
      ST_OP: begin
        if (bus.rx_valid) begin
          op_d    = bus.rx_data;
          chk_d   = bus.rx_data;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (bus.rx_valid) begin
          chk_d = chk_q ^ bus.rx_data;
          if (bus.rx_data > 8'(MAX_PAYLOAD)) begin
            err_len_d = sat_inc(err_len_q);
            state_d   = ST_IDLE;
          end else begin
            len_d   = bus.rx_data[LW-1:0];
            idx_d   = '0;
            state_d = (bus.rx_data == 8'd0) ? ST_CHK : ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (bus.rx_valid) begin
          wr_en = 1'b1;
          chk_d = chk_q ^ bus.rx_data;
          idx_d = idx_q + LW'(1);
          if (idx_q == len_q - LW'(1)) state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == chk_q) begin
            cmd_op_d  = op_q;
            cmd_len_d = len_q;
            state_d   = ST_HOLD;
          end else begin
            err_chk_d = sat_inc(err_chk_q);
            state_d   = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        // A byte landing on the acceptance cycle is still lost; the frame it began is not recovered.
        if (bus.rx_valid) err_drop_d = sat_inc(err_drop_q);
        if (bus.cmd_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Timeout only runs mid-frame; a byte restarts it, and it never races a byte-driven transition.
    if (state_q inside {ST_OP, ST_LEN, ST_PAYLOAD, ST_CHK} && !bus.rx_valid) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        err_tmo_d = sat_inc(err_tmo_q);
        state_d   = ST_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      chk_q      <= '0;
      cmd_op_q   <= '0;
      cmd_len_q  <= '0;
      tmo_q      <= '0;
      err_chk_q  <= '0;
      err_len_q  <= '0;
      err_drop_q <= '0;
      err_tmo_q  <= '0;
      pl_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      chk_q      <= chk_d;
      cmd_op_q   <= cmd_op_d;
      cmd_len_q  <= cmd_len_d;
      tmo_q      <= tmo_d;
      err_chk_q  <= err_chk_d;
      err_len_q  <= err_len_d;
      err_drop_q <= err_drop_d;
      err_tmo_q  <= err_tmo_d;
      pl_data_q  <= pl_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) pl_mem[wr_addr] <= bus.rx_data;
  end

  assign bus.cmd_valid = (state_q == ST_HOLD);
  assign bus.cmd_op    = cmd_op_q;
  assign bus.cmd_len   = cmd_len_q;
  assign bus.pl_data   = pl_data_q;
  assign bus.err_chk   = err_chk_q;
  assign bus.err_len   = err_len_q;
  assign bus.err_drop  = err_drop_q;
  assign bus.err_tmo   = err_tmo_q;
endmodule
